des_msg_ctrl: RTL

Parametrised front-end controller for the DES encryption core on the FPGA board. It debounces the user push buttons, fetches the selected plaintext from an external message ROM, and launches one encryption with a handshake timed to the core's fixed pipeline latency. It captures the ciphertext and drives a selectable DISP_W-bit slice plus one-hot decimal points to the 7-segment display driver.
It replaces hard-wired byte selection and single-flop debounce with generalised width, word count and full debounce.

---
 rtl/des_msg_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/des_msg_ctrl.sv
// Front-end controller for the DES core: button debounce, ROM fetch, timed launch, result display.
// Optional auto-scroll of the displayed word in DONE is enabled by defining DES_DISP_AUTOSCROLL_EN.
module des_msg_ctrl #(
    parameter int DATA_W     = 64,
    parameter int DISP_W     = 16,
    parameter int SEL_W      = 8,
    parameter int LATENCY    = 17,
    parameter int DB_CYC     = 16,
    parameter int SCROLL_CYC = 50000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       btn_start,
    input  logic                       btn_next,
    input  logic                       btn_clr,
    output logic [SEL_W-1:0]           msg_idx,
    input  logic [DATA_W-1:0]          msg_data,
    output logic [DATA_W-1:0]          core_in,
    output logic                       core_rst,
    input  logic [DATA_W-1:0]          core_out,
    output logic [DISP_W-1:0]          disp_data,
    output logic [DATA_W/DISP_W-1:0]   disp_dp,
    output logic                       busy,
    output logic                       done
);

    localparam int NWORDS = DATA_W / DISP_W;
    localparam int WSEL_W = $clog2(NWORDS);
    localparam int DB_W   = $clog2(DB_CYC);
    localparam int CNT_W  = $clog2(LATENCY + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    localparam int BTN_START = 0;
    localparam int BTN_NEXT  = 1;
    localparam int BTN_CLR   = 2;

    if (DATA_W % DISP_W != 0 || NWORDS < 2 || (NWORDS & (NWORDS - 1)) != 0 ||
        LATENCY < 1 || DB_CYC < 2 || SCROLL_CYC < 1) begin : g_param_check
        $error("des_msg_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    logic [SEL_W-1:0]               sel_meta, sel_sync;
    logic [2:0]                     btn_meta, btn_sync;
    logic [2:0]                     btn_level, btn_pulse;
    logic [DB_W-1:0]                db_cnt [3];

    state_t                         state;
    logic [CNT_W-1:0]               cnt;
    logic [NWORDS-1:0][DISP_W-1:0]  ct;
    logic [WSEL_W-1:0]              word_sel;

`ifdef DES_DISP_AUTOSCROLL_EN
    localparam int SCR_W = $clog2(SCROLL_CYC + 1);
    localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_CYC - 1);
    logic [SCR_W-1:0]               scroll_cnt;
`endif

    // Two-flop synchronisers for the asynchronous switches and buttons.
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_meta <= '0;
            sel_sync <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sel_meta <= sel;
            sel_sync <= sel_meta;
            btn_meta <= {btn_clr, btn_next, btn_start};
            btn_sync <= btn_meta;
        end
    end

    // The level flips after DB_CYC consecutive differing samples; a rising flip yields a 1-cycle pulse.
    // NOTE: the small counter array is reset element by element; this is flops, not a RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_level <= '0;
            btn_pulse <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                btn_pulse[i] <= 1'b0;
                if (btn_sync[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_level[i] <= btn_sync[i];
                    btn_pulse[i] <= btn_sync[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            msg_idx  <= '0;
            core_in  <= '0;
            core_rst <= 1'b1;
            cnt      <= '0;
            ct       <= '0;
            word_sel <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef DES_DISP_AUTOSCROLL_EN
            scroll_cnt <= '0;
`endif
        end else begin
            core_rst <= 1'b0;
            if (btn_pulse[BTN_CLR]) begin
                state    <= S_IDLE;
                core_in  <= '0;
                core_rst <= 1'b1;
                ct       <= '0;
                word_sel <= '0;
                busy     <= 1'b0;
                done     <= 1'b0;
`ifdef DES_DISP_AUTOSCROLL_EN
                scroll_cnt <= '0;
`endif
            end else begin
`ifdef DES_DISP_AUTOSCROLL_EN
                if (btn_pulse[BTN_NEXT]) begin
                    word_sel   <= word_sel + WSEL_W'(1);
                    scroll_cnt <= '0;
                end else if (state == S_DONE) begin
                    if (scroll_cnt == SCR_LAST) begin
                        word_sel   <= word_sel + WSEL_W'(1);
                        scroll_cnt <= '0;
                    end else begin
                        scroll_cnt <= scroll_cnt + SCR_W'(1);
                    end
                end
`else
                if (btn_pulse[BTN_NEXT]) word_sel <= word_sel + WSEL_W'(1);
`endif
                case (state)
                    S_IDLE, S_DONE: begin
                        if (btn_pulse[BTN_START]) begin
                            msg_idx <= sel_sync;
                            state   <= S_FETCH;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                    S_FETCH: state <= S_LOAD;
                    S_LOAD: begin
                        // ROM data is valid now: msg_idx was registered one cycle ago.
                        core_in <= msg_data;
                        cnt     <= CNT_LOAD;
                        state   <= S_RUN;
                    end
                    S_RUN: begin
                        if (cnt == '0) begin
                            ct    <= core_out;
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef DES_DISP_AUTOSCROLL_EN
                            scroll_cnt <= '0;
`endif
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign disp_data = ct[word_sel];
    assign disp_dp   = ~(NWORDS'(1) << word_sel);

endmodule
